fnd_scan_decoder: RTL
=====================

Name: fnd_scan_decoder

Overview:
Reader side of the 7-segment display interface. It watches a multiplexed, active-low, g~a segment bus together with its one-hot digit-select lines, and reconstructs the hex value shown on every digit. Used for loopback self-test of the display path and for capturing an external unit's multiplexed FND output. It reverses the hex-to-segment encoding and adds settle filtering, frame assembly and error flagging.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYC, 4, consecutive identical one-hot samples required before a digit is captured (>=1)

Ports:
i_Clk  in  1  system clock, rising edge
i_Rst  in  1  asynchronous, active-high reset
i_FND  in  7  segment pattern, active-low, bit6=g .. bit0=a
i_Com  in  DIGITS  digit select, active-high, expected one-hot
o_Value  out  4*DIGITS  last complete frame; nibble k = digit k (digit 0 in bits 3:0)
o_Blank  out  DIGITS  per-digit blank flag for the last complete frame
o_Valid  out  1  one-cycle pulse when o_Value/o_Blank update
o_Err  out  1  one-cycle pulse on a settled, unrecognised pattern
o_ErrDigit  out  3  index of the digit that caused the last o_Err, held until the next error

Behaviour:
- Reset (async, i_Rst=1): o_Value=0, o_Blank=all 1, o_Valid=0, o_Err=0, o_ErrDigit=0, frame mask=0, shadow regs=0, settle counter=0, FSM=IDLE. Reset mid-frame discards any partial frame.
- Reverse LUT (active-low g~a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0011000, A=0001000, b=0000011, c=0100111, d=0100001, E=0000110, F=0001110. Blank=1111111 -> nibble 0, blank=1. Any other pattern is invalid.
- One-hot check: i_Com with zero bits set or with more than one bit set is "not selected". Ghosting during a digit switch is normal and never raises o_Err.
- FSM states:
  - IDLE: waits for a one-hot i_Com. On that edge, latch {i_Com,i_FND} into the sample register, set cnt=1, then go to SETTLE, or go directly to CAPTURE-action if STABLE_CYC=1.
  - SETTLE: while inputs equal the sample and stay one-hot, cnt increments. If inputs change but remain one-hot, re-latch and set cnt=1 (stay in SETTLE). If inputs become not-one-hot, go to IDLE and set cnt=0. When cnt reaches STABLE_CYC, perform the capture action on that edge and go to HELD.
  - HELD: stays while inputs equal the sample, so no re-capture happens. On any change, re-evaluate as in IDLE on the same edge.
- Capture action for digit k:
  - Valid pattern: write the nibble and blank flag into the shadow slot k and set mask bit k. If bit k was already set, overwrite the slot and leave the mask unchanged.
  - Invalid pattern: o_Err=1 for one cycle, o_ErrDigit=k, clear the whole mask (frame aborted), shadow slot unchanged.
- Frame complete: on the edge where the mask becomes all ones, o_Value and o_Blank load atomically from shadow plus the newly captured digit, and o_Valid=1 next cycle for exactly one cycle. The mask clears on that same edge.
- Latency: from the first edge with stable inputs to capture is STABLE_CYC edges. o_Valid is asserted in the cycle after the capture edge of the final digit.
- Scan order is irrelevant; only mask coverage counts.
- Counter width is $clog2(STABLE_CYC+1). The counter saturates and never wraps.

Decomposition:
- Package fnd_pkg: the 17 segment-pattern constants (including SEG_BLANK), the FSM state enum {IDLE,SETTLE,HELD}, and the MAX_DIGITS=8 constant.
- Sub-module fnd_pattern_decode: combinational i_FND -> {nibble, blank, invalid}, built from the fnd_pkg constants.

Test Plan:
- Scan digits 0..3 showing 1,2,3,4, each held 6 cycles, STABLE_CYC=4 -> one o_Valid pulse, o_Value=16'h4321, o_Blank=4'b0000.
- Digit 2 held for only 3 cycles, then i_Com=0 -> no capture for digit 2, no o_Valid, no o_Err. A later full 4-cycle hold on digit 2 completes the frame.
- Digit 1 shows 7'b1111110 (invalid) held 4 cycles mid-frame -> o_Err pulse, o_ErrDigit=1, mask cleared. o_Value keeps its previous frame.
- i_Com=4'b0110 for 10 cycles with valid segments -> nothing captured, no o_Err.
- Digit 3 blank (1111111), others show E,F,0 -> o_Value=16'h00FE with digit 3 nibble 0, o_Blank=4'b1000.
- Assert i_Rst after 3 of 4 digits are captured, then scan a full frame showing A,b,c,d -> o_Valid is asserted only after all 4 digits post-reset, o_Value=16'hDCBA.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants for the multiplexed 7-segment reader: active-low g..a
// segment patterns, FSM state encoding and the digit-count ceiling.
package fnd_pkg;
    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1011000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b0100111;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_e;
endpackage

// File: rtl/fnd_pattern_decode.sv
// Reverse segment LUT: active-low g..a pattern to hex nibble, with blank
// and invalid flags. Purely combinational.
module fnd_pattern_decode
    import fnd_pkg::*;
(
    input  logic [6:0] i_FND,
    output logic [3:0] o_Nibble,
    output logic       o_Blank,
    output logic       o_Invalid
);
    always_comb begin
        o_Nibble  = 4'h0;
        o_Blank   = 1'b0;
        o_Invalid = 1'b0;
        case (i_FND)
            SEG_0:     o_Nibble = 4'h0;
            SEG_1:     o_Nibble = 4'h1;
            SEG_2:     o_Nibble = 4'h2;
            SEG_3:     o_Nibble = 4'h3;
            SEG_4:     o_Nibble = 4'h4;
            SEG_5:     o_Nibble = 4'h5;
            SEG_6:     o_Nibble = 4'h6;
            SEG_7:     o_Nibble = 4'h7;
            SEG_8:     o_Nibble = 4'h8;
            SEG_9:     o_Nibble = 4'h9;
            SEG_A:     o_Nibble = 4'hA;
            SEG_B:     o_Nibble = 4'hB;
            SEG_C:     o_Nibble = 4'hC;
            SEG_D:     o_Nibble = 4'hD;
            SEG_E:     o_Nibble = 4'hE;
            SEG_F:     o_Nibble = 4'hF;
            SEG_BLANK: o_Blank  = 1'b1;
            default:   o_Invalid = 1'b1;
        endcase
    end
endmodule

// File: rtl/fnd_scan_decoder.sv
// Multiplexed FND reader: settles each one-hot digit select, decodes the
// segment pattern and assembles complete frames of DIGITS hex values.
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [6:0]            i_FND,
    input  logic [DIGITS-1:0]     i_Com,
    output logic [4*DIGITS-1:0]   o_Value,
    output logic [DIGITS-1:0]     o_Blank,
    output logic                  o_Valid,
    output logic                  o_Err,
    output logic [2:0]            o_ErrDigit
);
    localparam int CW = $clog2(STABLE_CYC + 1);

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [DIGITS-1:0]        smp_com_q, smp_com_d;
    logic [6:0]               smp_fnd_q, smp_fnd_d;
    logic [DIGITS-1:0]        mask_q, mask_d;
    logic [DIGITS-1:0][3:0]   shadow_q, shadow_d;
    logic [DIGITS-1:0]        shblk_q, shblk_d;
    logic [4*DIGITS-1:0]      value_q, value_d;
    logic [DIGITS-1:0]        blank_q, blank_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;
    logic [2:0]               errdig_q, errdig_d;

    logic [3:0] dec_nib;
    logic       dec_blank, dec_inv;
    logic       onehot, same, start, capture;
    logic [2:0] idx;

    fnd_pattern_decode u_dec (
        .i_FND     (i_FND),
        .o_Nibble  (dec_nib),
        .o_Blank   (dec_blank),
        .o_Invalid (dec_inv)
    );

    assign onehot = (i_Com != '0) && ((i_Com & (i_Com - DIGITS'(1))) == '0);
    assign same   = (i_Com == smp_com_q) && (i_FND == smp_fnd_q);

    always_comb begin
        idx = 3'd0;
        for (int k = 0; k < DIGITS; k++)
            if (i_Com[k]) idx = 3'(k);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        smp_com_d = smp_com_q;
        smp_fnd_d = smp_fnd_q;
        mask_d    = mask_q;
        shadow_d  = shadow_q;
        shblk_d   = shblk_q;
        value_d   = value_q;
        blank_d   = blank_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        errdig_d  = errdig_q;
        start     = 1'b0;
        capture   = 1'b0;

        case (state_q)
            IDLE: start = onehot;
            SETTLE: begin
                if (onehot && same) begin
                    if (cnt_q == CW'(STABLE_CYC - 1)) begin
                        cnt_d   = CW'(STABLE_CYC);
                        capture = 1'b1;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (onehot) begin
                    start = 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            HELD: begin
                if (!same) begin
                    if (onehot) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A change in the inputs restarts settling from the new sample.
        if (start) begin
            smp_com_d = i_Com;
            smp_fnd_d = i_FND;
            cnt_d     = CW'(1);
            if (STABLE_CYC == 1) begin
                capture = 1'b1;
                state_d = HELD;
            end else begin
                state_d = SETTLE;
            end
        end

        if (capture) begin
            if (dec_inv) begin
                err_d    = 1'b1;
                errdig_d = idx;
                mask_d   = '0;
            end else begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (i_Com[k]) begin
                        shadow_d[k] = dec_nib;
                        shblk_d[k]  = dec_blank;
                    end
                end
                if ((mask_q | i_Com) == '1) begin
                    value_d = shadow_d;
                    blank_d = shblk_d;
                    valid_d = 1'b1;
                    mask_d  = '0;
                end else begin
                    mask_d = mask_q | i_Com;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            smp_com_q <= '0;
            smp_fnd_q <= '0;
            mask_q    <= '0;
            shadow_q  <= '0;
            shblk_q   <= '0;
            value_q   <= '0;
            blank_q   <= '1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            errdig_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            smp_com_q <= smp_com_d;
            smp_fnd_q <= smp_fnd_d;
            mask_q    <= mask_d;
            shadow_q  <= shadow_d;
            shblk_q   <= shblk_d;
            value_q   <= value_d;
            blank_q   <= blank_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            errdig_q  <= errdig_d;
        end
    end

    assign o_Value    = value_q;
    assign o_Blank    = blank_q;
    assign o_Valid    = valid_q;
    assign o_Err      = err_q;
    assign o_ErrDigit = errdig_q;
endmodule
